// File: rtl/mux_rr_arbiter_if.sv
// Bus between the requesters/mux datapath and the round-robin arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] data_inputs;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       data_out;

    modport master (
        output req,
        output data_inputs,
        input  grant,
        input  select,
        input  busy,
        input  data_out
    );

    modport slave (
        input  req,
        input  data_inputs,
        output grant,
        output select,
        output busy,
        output data_out
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a 4:1 mux select. Issues a registered
// one-hot grant with hold-until-release ownership, drives the encoded
// select, and registers the selected data bit one edge later.
// Optional macro MUX_ARB_TIMEOUT_EN adds a hold counter that forces a
// handover after HOLD_MAX consecutive cycles when others are waiting.
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);

    // Reject illegal hold limits at elaboration time.
    if (HOLD_MAX < 2) begin : g_bad_hold_max
        $error("mux_rr_arbiter: HOLD_MAX must be >= 2");
    end

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] select_q, select_d;
    logic       busy_q, busy_d;
    logic       data_out_q, data_out_d;

    logic [2:0] pick;        // {found, index} from the priority pointer
    logic       new_grant;
    logic [1:0] new_idx;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]       force_pick;  // {found, index} among non-owners only
`endif

    // First set request scanning start, start+1, start+2, start+3 (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] req_vec,
                                           input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Scan from the far end so the nearest hit is written last.
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req_vec[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Next-state, grant selection and registered data mux.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        select_d   = select_q;
        busy_d     = busy_q;
        new_grant  = 1'b0;
        new_idx    = select_q;
        pick       = rr_pick(bus.req, ptr_q);
`ifdef MUX_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        force_pick = rr_pick(bus.req & ~grant_q, select_q + 2'd1);
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    new_grant = 1'b1;
                    new_idx   = pick[1:0];
                end
            end
            ST_GRANT: begin
                if (bus.req[select_q]) begin
`ifdef MUX_ARB_TIMEOUT_EN
                    // Owner still requesting: force a handover once the
                    // hold limit is reached and someone else is waiting.
                    if (hold_cnt_q == CNT_LAST && force_pick[2]) begin
                        new_grant = 1'b1;
                        new_idx   = force_pick[1:0];
                    end else if (hold_cnt_q != CNT_LAST) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
`endif
                end else if (pick[2]) begin
                    // Owner released with others pending: direct handover.
                    new_grant = 1'b1;
                    new_idx   = pick[1:0];
                end else begin
                    // Owner released, nobody waiting: go idle, keep select.
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (new_grant) begin
            grant_d    = 4'b0001 << new_idx;
            select_d   = new_idx;
            ptr_d      = new_idx + 2'd1;
            busy_d     = 1'b1;
            state_d    = ST_GRANT;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end

        data_out_d = busy_q ? bus.data_inputs[select_q] : 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            grant_q    <= 4'b0000;
            select_q   <= 2'd0;
            busy_q     <= 1'b0;
            data_out_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            select_q   <= select_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.select   = select_q;
    assign bus.busy     = busy_q;
    assign bus.data_out = data_out_q;

endmodule
